ex_mc_sequencer: RTL and testbench

Sequences multi-cycle execute-stage operations: FP add/sub/mul/div, int-float conversions and integer mul/div/mod. It accepts one op from EX, drives start/select to the pipelined functional unit and counts that op's latency. It asserts busy so the front end stalls, then captures the FU result and holds it until writeback acknowledges. Single-cycle ops bypass this block; it replaces the hard-wired BUSY=0 in the execute stage.

---
 rtl/ex_mc_sequencer.sv | 146 ++++++++++++++
 tb/tb_ex_mc_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mc_sequencer.sv
// Multi-cycle execute-stage sequencer: accepts one FP/INT long-latency op, times it
// against the functional unit, then holds the result until writeback takes it.
module ex_mc_sequencer #(
    parameter int LAT_FADD = 7,
    parameter int LAT_FMUL = 6,
    parameter int LAT_FDIV = 6,
    parameter int LAT_CVT  = 2,
    parameter int LAT_IMUL = 3,
    parameter int LAT_IDIV = 8,
    parameter int CNT_W    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic        issue_unit,
    input  logic [3:0]  issue_op,
    input  logic [4:0]  issue_dst,
    output logic        issue_ready,
    output logic        mc_op,
    output logic        fu_start,
    output logic [3:0]  fu_op,
    output logic        fu_unit,
    output logic        fu_addsub,
    output logic        fu_kill,
    input  logic [31:0] fu_result,
    input  logic        flush,
    output logic        busy,
    output logic        done_valid,
    output logic [31:0] done_data,
    output logic [4:0]  done_dst,
    output logic        done_unit,
    input  logic        done_ack
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       dst_q;
    logic             accept;
    logic             run_end;

    function automatic logic is_mc(input logic unit, input logic [3:0] op);
        case ({unit, op})
            5'b1_1000, 5'b1_1001, 5'b1_1011, 5'b1_1100,
            5'b1_1101, 5'b1_1110,
            5'b0_0011, 5'b0_0100, 5'b0_0101: is_mc = 1'b1;
            default:                         is_mc = 1'b0;
        endcase
    endfunction

    // Counter preload is LAT-1 so that RUN spans exactly LAT cycles.
    function automatic logic [CNT_W-1:0] lat_m1(input logic unit, input logic [3:0] op);
        case ({unit, op})
            5'b1_1000, 5'b1_1001: lat_m1 = CNT_W'(LAT_CVT - 1);
            5'b1_1011, 5'b1_1100: lat_m1 = CNT_W'(LAT_FADD - 1);
            5'b1_1101:            lat_m1 = CNT_W'(LAT_FMUL - 1);
            5'b1_1110:            lat_m1 = CNT_W'(LAT_FDIV - 1);
            5'b0_0011:            lat_m1 = CNT_W'(LAT_IMUL - 1);
            5'b0_0100, 5'b0_0101: lat_m1 = CNT_W'(LAT_IDIV - 1);
            default:              lat_m1 = '0;
        endcase
    endfunction

    assign mc_op     = is_mc(issue_unit, issue_op);
    assign fu_addsub = (state == RUN) && fu_unit && (fu_op == 4'b1011);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        issue_ready = 1'b0;
        busy        = 1'b0;
        done_valid  = 1'b0;
        accept      = 1'b0;
        run_end     = 1'b0;
        case (state)
            IDLE: begin
                issue_ready = 1'b1;
                accept      = issue_valid && mc_op && !flush;
                busy        = accept;
                if (accept) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == '0) begin
                    run_end   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_valid  = 1'b1;
                issue_ready = done_ack;
                busy        = !done_ack;
                if (flush) begin
                    state_nxt = IDLE;
                end else if (done_ack) begin
                    // Back-to-back issue reuses the ack cycle, no IDLE bubble.
                    accept    = issue_valid && mc_op;
                    state_nxt = accept ? RUN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (rst) begin
            issue_ready = 1'b0;
            busy        = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            fu_start  <= 1'b0;
            fu_kill   <= 1'b0;
            fu_op     <= '0;
            fu_unit   <= 1'b0;
            dst_q     <= '0;
            done_data <= '0;
            done_dst  <= '0;
            done_unit <= 1'b0;
        end else begin
            fu_start <= accept;
            fu_kill  <= (state == RUN) && flush;
            if (accept) begin
                cnt     <= lat_m1(issue_unit, issue_op);
                fu_op   <= issue_op;
                fu_unit <= issue_unit;
                dst_q   <= issue_dst;
            end else if ((state == RUN) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (run_end) begin
                done_data <= fu_result;
                done_dst  <= dst_q;
                done_unit <= fu_unit;
            end
        end
    end

endmodule

// File: tb/tb_ex_mc_sequencer.sv
// Directed bench for ex_mc_sequencer: per-cycle vector table plus hand sequences
// for single-cycle latency and asynchronous reset mid-RUN.
module tb_ex_mc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_unit, flush, done_ack;
    logic [3:0]  issue_op;
    logic [4:0]  issue_dst;
    logic [31:0] fu_result;

    logic        issue_ready, mc_op, fu_start, fu_unit, fu_addsub, fu_kill;
    logic        busy, done_valid, done_unit;
    logic [3:0]  fu_op;
    logic [31:0] done_data;
    logic [4:0]  done_dst;

    logic        c_ready, c_mc, c_start, c_unit, c_addsub, c_kill, c_busy, c_dv, c_du;
    logic [3:0]  c_op;
    logic [31:0] c_dd;
    logic [4:0]  c_ddst;

    int total = 0;
    int bad   = 0;

    ex_mc_sequencer dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_unit(issue_unit),
        .issue_op(issue_op), .issue_dst(issue_dst), .issue_ready(issue_ready),
        .mc_op(mc_op), .fu_start(fu_start), .fu_op(fu_op), .fu_unit(fu_unit),
        .fu_addsub(fu_addsub), .fu_kill(fu_kill), .fu_result(fu_result),
        .flush(flush), .busy(busy), .done_valid(done_valid), .done_data(done_data),
        .done_dst(done_dst), .done_unit(done_unit), .done_ack(done_ack)
    );

    ex_mc_sequencer #(.LAT_CVT(1)) dut_cvt1 (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_unit(issue_unit),
        .issue_op(issue_op), .issue_dst(issue_dst), .issue_ready(c_ready),
        .mc_op(c_mc), .fu_start(c_start), .fu_op(c_op), .fu_unit(c_unit),
        .fu_addsub(c_addsub), .fu_kill(c_kill), .fu_result(fu_result),
        .flush(flush), .busy(c_busy), .done_valid(c_dv), .done_data(c_dd),
        .done_dst(c_ddst), .done_unit(c_du), .done_ack(done_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic        u;
        logic [3:0]  op;
        logic [4:0]  dst;
        logic        fl;
        logic        ack;
        logic        rdy;
        logic        mc;
        logic        busy;
        logic        st;
        logic        kill;
        logic        as;
        logic        dv;
        logic [31:0] dd;
        logic [4:0]  ddst;
        logic        du;
    } vec_t;

    vec_t tv[$];

    task automatic add(input logic iv, input logic u, input logic [3:0] op,
                       input logic [4:0] dst, input logic fl, input logic ack,
                       input logic rdy, input logic mc, input logic bsy, input logic st,
                       input logic kill, input logic as, input logic dv,
                       input logic [31:0] dd, input logic [4:0] ddst, input logic du);
        vec_t v;
        v.iv = iv; v.u = u; v.op = op; v.dst = dst; v.fl = fl; v.ack = ack;
        v.rdy = rdy; v.mc = mc; v.busy = bsy; v.st = st; v.kill = kill; v.as = as;
        v.dv = dv; v.dd = dd; v.ddst = ddst; v.du = du;
        tv.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic u, input logic [3:0] op,
                         input logic [4:0] dst, input logic fl, input logic ack);
        issue_valid = iv; issue_unit = u; issue_op = op; issue_dst = dst;
        flush = fl; done_ack = ack;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 4'h0, 5'd0, 0, 0);
        fu_result = '0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst busy", busy, 0);
        chk("rst ready", issue_ready, 0);
        chk("rst start", fu_start, 0);
        chk("rst dv", done_valid, 0);
        chk("rst data", done_data, 0);
        chk("rst fu_op", fu_op, 0);
        rst = 1'b0;

        // fadd dst=3, LAT 7
        add(1,1,4'hB,5'd3,0,0, 1,1,1,0,0,0,0, 32'h0,5'd0,0);                      // 0
        add(0,0,4'h0,5'd0,0,0, 0,0,1,1,0,1,0, 32'h0,5'd0,0);                      // 1
        repeat (6) add(0,0,4'h0,5'd0,0,0, 0,0,1,0,0,1,0, 32'h0,5'd0,0);           // 2-7
        add(0,0,4'h0,5'd0,0,1, 1,0,0,0,0,0,1, 32'h5A000007,5'd3,1);               // 8
        add(0,0,4'h0,5'd0,0,0, 1,0,0,0,0,0,0, 32'h5A000007,5'd3,1);               // 9
        // int div dst=9, LAT 8, ack held off 3 cycles
        add(1,0,4'h4,5'd9,0,0, 1,1,1,0,0,0,0, 32'h5A000007,5'd3,1);               // 10
        add(0,0,4'h0,5'd0,0,0, 0,0,1,1,0,0,0, 32'h5A000007,5'd3,1);               // 11
        repeat (7) add(0,0,4'h0,5'd0,0,0, 0,0,1,0,0,0,0, 32'h5A000007,5'd3,1);    // 12-18
        repeat (3) add(0,0,4'h0,5'd0,0,0, 0,0,1,0,0,0,1, 32'h5A000012,5'd9,0);    // 19-21
        add(0,0,4'h0,5'd0,0,1, 1,0,0,0,0,0,1, 32'h5A000012,5'd9,0);               // 22
        add(0,0,4'h0,5'd0,0,0, 1,0,0,0,0,0,0, 32'h5A000012,5'd9,0);               // 23
        // fmul dst=5, then fdiv dst=7 issued on the ack cycle
        add(1,1,4'hD,5'd5,0,0, 1,1,1,0,0,0,0, 32'h5A000012,5'd9,0);               // 24
        add(0,0,4'h0,5'd0,0,0, 0,0,1,1,0,0,0, 32'h5A000012,5'd9,0);               // 25
        repeat (5) add(0,0,4'h0,5'd0,0,0, 0,0,1,0,0,0,0, 32'h5A000012,5'd9,0);    // 26-30
        add(1,1,4'hE,5'd7,0,1, 1,1,0,0,0,0,1, 32'h5A00001E,5'd5,1);               // 31
        add(0,0,4'h0,5'd0,0,0, 0,0,1,1,0,0,0, 32'h5A00001E,5'd5,1);               // 32
        repeat (5) add(0,0,4'h0,5'd0,0,0, 0,0,1,0,0,0,0, 32'h5A00001E,5'd5,1);    // 33-37
        add(0,0,4'h0,5'd0,0,1, 1,0,0,0,0,0,1, 32'h5A000025,5'd7,1);               // 38
        add(0,0,4'h0,5'd0,0,0, 1,0,0,0,0,0,0, 32'h5A000025,5'd7,1);               // 39
        // fsub dst=2, flushed in 3rd RUN cycle
        add(1,1,4'hC,5'd2,0,0, 1,1,1,0,0,0,0, 32'h5A000025,5'd7,1);               // 40
        add(0,0,4'h0,5'd0,0,0, 0,0,1,1,0,0,0, 32'h5A000025,5'd7,1);               // 41
        add(0,0,4'h0,5'd0,0,0, 0,0,1,0,0,0,0, 32'h5A000025,5'd7,1);               // 42
        add(0,0,4'h0,5'd0,1,0, 0,0,1,0,0,0,0, 32'h5A000025,5'd7,1);               // 43
        add(0,0,4'h0,5'd0,0,0, 1,0,0,0,1,0,0, 32'h5A000025,5'd7,1);               // 44
        add(0,0,4'h0,5'd0,0,0, 1,0,0,0,0,0,0, 32'h5A000025,5'd7,1);               // 45
        // issue dropped by flush in IDLE
        add(1,1,4'hB,5'd6,1,0, 1,1,0,0,0,0,0, 32'h5A000025,5'd7,1);               // 46
        add(0,0,4'h0,5'd0,0,0, 1,0,0,0,0,0,0, 32'h5A000025,5'd7,1);               // 47
        // imul dst=4, DONE with flush+ack+issue together
        add(1,0,4'h3,5'd4,0,0, 1,1,1,0,0,0,0, 32'h5A000025,5'd7,1);               // 48
        add(0,0,4'h0,5'd0,0,0, 0,0,1,1,0,0,0, 32'h5A000025,5'd7,1);               // 49
        repeat (2) add(0,0,4'h0,5'd0,0,0, 0,0,1,0,0,0,0, 32'h5A000025,5'd7,1);    // 50-51
        add(1,1,4'hB,5'd6,1,1, 1,1,0,0,0,0,1, 32'h5A000033,5'd4,0);               // 52
        add(0,0,4'h0,5'd0,0,0, 1,0,0,0,0,0,0, 32'h5A000033,5'd4,0);               // 53
        // fneg is not multi-cycle
        add(1,1,4'hA,5'd6,0,0, 1,0,0,0,0,0,0, 32'h5A000033,5'd4,0);               // 54
        add(0,0,4'h0,5'd0,0,0, 1,0,0,0,0,0,0, 32'h5A000033,5'd4,0);               // 55

        for (int i = 0; i < tv.size(); i++) begin
            @(posedge clk); #1;
            drive(tv[i].iv, tv[i].u, tv[i].op, tv[i].dst, tv[i].fl, tv[i].ack);
            fu_result = 32'h5A000000 + 32'(i);
            #3;
            chk($sformatf("v%0d ready", i), issue_ready, tv[i].rdy);
            chk($sformatf("v%0d mc_op", i), mc_op, tv[i].mc);
            chk($sformatf("v%0d busy", i), busy, tv[i].busy);
            chk($sformatf("v%0d fu_start", i), fu_start, tv[i].st);
            chk($sformatf("v%0d fu_kill", i), fu_kill, tv[i].kill);
            chk($sformatf("v%0d fu_addsub", i), fu_addsub, tv[i].as);
            chk($sformatf("v%0d done_valid", i), done_valid, tv[i].dv);
            chk($sformatf("v%0d done_data", i), done_data, tv[i].dd);
            chk($sformatf("v%0d done_dst", i), done_dst, tv[i].ddst);
            chk($sformatf("v%0d done_unit", i), done_unit, tv[i].du);
        end

        // LAT_CVT=1 instance: itof dst=11 gives one RUN cycle
        @(posedge clk); #1;
        drive(1, 1, 4'h8, 5'd11, 0, 0);
        fu_result = 32'h0;
        #3;
        chk("cvt accept busy", c_busy, 1);
        chk("cvt accept ready", c_ready, 1);
        chk("cvt mc_op", c_mc, 1);
        @(posedge clk); #1;
        drive(0, 0, 4'h0, 5'd0, 0, 0);
        fu_result = 32'hCAFE0001;
        #3;
        chk("cvt start", c_start, 1);
        chk("cvt run busy", c_busy, 1);
        chk("cvt fu_op", c_op, 4'h8);
        chk("cvt fu_unit", c_unit, 1);
        chk("cvt addsub", c_addsub, 0);
        chk("cvt run dv", c_dv, 0);
        @(posedge clk); #1;
        drive(0, 0, 4'h0, 5'd0, 0, 1);
        fu_result = 32'h0;
        #3;
        chk("cvt dv", c_dv, 1);
        chk("cvt data", c_dd, 32'hCAFE0001);
        chk("cvt dst", c_ddst, 5'd11);
        chk("cvt unit", c_du, 1);
        chk("cvt kill", c_kill, 0);
        @(posedge clk); #1;
        drive(0, 0, 4'h0, 5'd0, 0, 0);
        #3;
        chk("cvt idle dv", c_dv, 0);
        chk("cvt idle busy", c_busy, 0);

        // Main instance: asynchronous reset in the middle of an fadd RUN
        @(posedge clk); #1;
        drive(0, 0, 4'h0, 5'd0, 0, 1);
        @(posedge clk); #1;
        drive(1, 1, 4'hB, 5'd3, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 4'h0, 5'd0, 0, 0);
        #3;
        chk("pre-rst fu_op", fu_op, 4'hB);
        chk("pre-rst fu_unit", fu_unit, 1);
        chk("pre-rst addsub", fu_addsub, 1);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst busy", busy, 0);
        chk("arst ready", issue_ready, 0);
        chk("arst fu_op", fu_op, 0);
        chk("arst fu_unit", fu_unit, 0);
        chk("arst addsub", fu_addsub, 0);
        chk("arst dv", done_valid, 0);
        chk("arst data", done_data, 0);
        chk("arst dst", done_dst, 0);
        chk("arst unit", done_unit, 0);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        drive(1, 1, 4'hA, 5'd6, 0, 0);
        #3;
        chk("fneg mc_op", mc_op, 0);
        chk("fneg busy", busy, 0);
        chk("fneg ready", issue_ready, 1);
        @(posedge clk); #1;
        drive(0, 0, 4'h0, 5'd0, 0, 0);
        #3;
        chk("fneg start", fu_start, 0);
        chk("fneg busy2", busy, 0);
        repeat (8) @(posedge clk);
        #1;
        chk("post-rst dv", done_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
